// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, arbiter state encoding and a
// small index-width helper used by the output arbiter and its picker.
package noc_pkg;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_S     = 3;
  localparam int PORT_W     = 4;
  localparam int NUM_PORTS  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of an index into n items; never below 1 so one-port builds stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin selector: the first unmasked request found when
// scanning ptr+1, ptr+2, ... modulo N wins.
module noc_rr_pick
  import noc_pkg::*;
#(
  parameter  int N  = NUM_PORTS,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          found
);

  logic [N-1:0] eligible;
  logic [N-1:0] sel;

  assign eligible = req & ~mask;

  // NOTE: every output and temporary gets a default first, so no path through
  // the loop leaves a value held and no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int k = 1; k <= N; k++) begin
      sel = N'(1) << ((int'(ptr) + k) % N);
      if (!found && |(eligible & sel)) begin
        winner = sel;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Wormhole round-robin arbiter for one NoC router output link. Optional
// per-input completed-packet counters are built when NOC_ARB_STATS_EN is defined.
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_last,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        grant,
  output logic                     busy
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [NUM_IN*CNT_W-1:0]  pkt_cnt
`endif
);

  localparam int IW = idx_w(NUM_IN);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("noc_out_arbiter: CNT_W must be at least 1");
  end

  arb_state_e      state;
  logic [IW-1:0]   own;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick_ptr;
  logic [IW-1:0]   win_idx;
  logic [NUM_IN-1:0] winner;
  logic            found;
  logic            xfer;
  logic            tail_xfer;

  // One picker serves both paths: in IDLE it scans from the last owner with
  // nothing masked; on a tail it scans from the current owner with that owner
  // masked (grant is all zero in IDLE, so it doubles as the mask).
  assign pick_ptr = (state == LOCKED) ? own : ptr;

  noc_rr_pick #(
    .N (NUM_IN)
  ) u_pick (
    .req    (in_valid),
    .mask   (grant),
    .ptr    (pick_ptr),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (winner[i]) win_idx = IW'(i);
    end
  end

  // Owner-to-output steering is purely combinational; grant is one-hot while locked.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    in_ready  = '0;
    if (state == LOCKED) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant[i]) begin
          out_valid   = in_valid[i];
          out_last    = in_last[i];
          out_data    = in_data[i*DATA_W +: DATA_W];
          in_ready[i] = out_ready;
        end
      end
    end
  end

  assign xfer      = out_valid & out_ready;
  assign tail_xfer = xfer & out_last;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
      ptr   <= IW'(NUM_IN - 1);
      own   <= '0;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= LOCKED;
            own   <= win_idx;
            grant <= winner;
            busy  <= 1'b1;
          end
        end
        LOCKED: begin
          if (tail_xfer) begin
            ptr <= own;
            if (found) begin
              own   <= win_idx;
              grant <= winner;
            end else begin
              state <= IDLE;
              grant <= '0;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_IN];

  // NOTE: the counter array is a small register file, not a RAM, so it is
  // cleared element by element on reset like any other state.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else if (tail_xfer) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Scoreboard bench for noc_out_arbiter: directed packet loads push the
// hand-ordered expected flit stream; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_noc_out_arbiter;

  localparam int NUM_IN = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic                     clk = 1'b0;
  logic                     srst = 1'b1;
  logic [NUM_IN-1:0]        in_valid = '0;
  logic [NUM_IN-1:0]        in_last = '0;
  logic [DATA_W-1:0]        drv_data [NUM_IN];
  wire  [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic                     out_last;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready = 1'b0;
  logic [NUM_IN-1:0]        grant;
  logic                     busy;
`ifdef NOC_ARB_STATS_EN
  logic [NUM_IN*CNT_W-1:0]  pkt_cnt;
`endif

  for (genvar g = 0; g < NUM_IN; g++) begin : g_data
    assign in_data[g*DATA_W +: DATA_W] = drv_data[g];
  end

  noc_out_arbiter #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
`ifdef NOC_ARB_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } flit_t;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  flit_t             src_q [NUM_IN][$];
  exp_t              exp_q [$];
  int                cyc_q [$];
  int                n_cmp  = 0;
  int                n_bad  = 0;
  int                n_xfer = 0;
  int                cyc    = 0;
  logic [NUM_IN-1:0] fire   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int port, input int pkt, input int flit);
    return {8'(port), 8'(pkt), 16'(flit)};
  endfunction

  // Packets are loaded in the grant order worked out by hand for each test,
  // so the expected stream is simply the load order.
  task automatic load_pkt(input int port, input int pkt, input int n);
    for (int f = 0; f < n; f++) begin
      src_q[port].push_back('{data: mk(port, pkt, f), last: (f == n - 1)});
      exp_q.push_back('{port: port, data: mk(port, pkt, f), last: (f == n - 1)});
    end
  endtask

  always @(posedge clk) cyc++;

  // Source side of every input link: hold a flit until it is accepted.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NUM_IN; i++) begin
      if (fire[i] && src_q[i].size() > 0) src_q[i].delete(0);
      if (src_q[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_last[i]  = src_q[i][0].last;
        drv_data[i] = src_q[i][0].data;
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        drv_data[i] = '0;
      end
    end
    fire = '0;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (!srst) begin
      fire = in_valid & in_ready;
      if (out_valid && out_ready) begin
        n_xfer++;
        cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 64'(out_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("xfer_grant",    64'(grant),    64'(1) << e.port);
          check("xfer_in_ready", 64'(in_ready), 64'(1) << e.port);
          check("xfer_data",     64'(out_data), 64'(e.data));
          check("xfer_last",     64'(out_last), 64'(e.last));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    srst = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    exp_q.delete();
    cyc_q.delete();
    n_xfer = 0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) check({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_grant(input string name, input logic [NUM_IN-1:0] g, input int budget);
    int k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (grant !== g && k < budget);
    check(name, 64'(grant), 64'(g));
  endtask

  task automatic wait_xfers(input string name, input int target, input int budget);
    int k = 0;
    while (n_xfer < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_xfer < target) check({name, "_xfer_timeout"}, 64'(n_xfer), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_IN; i++) drv_data[i] = '0;

    // Reset values, then one 3-flit packet from input 0.
    do_reset();
    @(negedge clk);
    check("rst_grant",     64'(grant),     64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
`ifdef NOC_ARB_STATS_EN
    check("rst_pkt_cnt",   64'(pkt_cnt),   64'd0);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    load_pkt(0, 1, 3);
    @(negedge clk);
    check("arb_cycle_grant",    64'(grant),    64'd0);
    check("arb_cycle_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t1_grant", 64'(grant), 64'b00001);
    check("t1_busy",  64'(busy),  64'd1);
    wait_drain("t1", 20);
    @(negedge clk);
    check("t1_idle_busy",  64'(busy),   64'd0);
    check("t1_idle_grant", 64'(grant),  64'd0);
    check("t1_xfers",      64'(n_xfer), 64'd3);

    // All inputs: order 0,1,2,3,4,0 with no gap between tails.
    do_reset();
    out_ready = 1'b1;
    load_pkt(0, 2, 1);
    load_pkt(1, 2, 1);
    load_pkt(2, 2, 1);
    load_pkt(3, 2, 1);
    load_pkt(4, 2, 1);
    load_pkt(0, 3, 1);
    wait_drain("t2", 40);
    check("t2_xfers", 64'(n_xfer), 64'd6);
    if (cyc_q.size() == 6) check("t2_no_bubble", 64'(cyc_q[5] - cyc_q[0]), 64'd5);
    else check("t2_xfer_log", 64'(cyc_q.size()), 64'd6);

    // Input 2 locked and stalled mid-packet while input 1 waits.
    do_reset();
    out_ready = 1'b1;
    load_pkt(2, 4, 4);
    wait_grant("t3_grant2", 5'b00100, 20);
    @(posedge clk); #1;
    load_pkt(1, 4, 2);
    wait_xfers("t3", 2, 20);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("t3_stall_grant",    64'(grant),     64'b00100);
      check("t3_stall_in_ready", 64'(in_ready),  64'd0);
      check("t3_stall_valid",    64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("t3", 40);
    check("t3_xfers", 64'(n_xfer), 64'd6);

    // Input 3 alone, two packets: one IDLE cycle between tail and head.
    do_reset();
    out_ready = 1'b1;
    load_pkt(3, 5, 2);
    load_pkt(3, 6, 2);
    wait_drain("t4", 40);
    if (cyc_q.size() == 4) check("t4_one_bubble", 64'(cyc_q[2] - cyc_q[1]), 64'd2);
    else check("t4_xfer_log", 64'(cyc_q.size()), 64'd4);

    // Reset on the 2nd flit of input 2's packet, after input 1 moved ptr to 1.
    do_reset();
    out_ready = 1'b1;
    load_pkt(1, 7, 1);
    load_pkt(2, 7, 4);
    wait_xfers("t5", 2, 20);
    @(posedge clk); #1;
    srst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    srst = 1'b0;
    check("t5_dropped_flits", 64'(exp_q.size()), 64'd3);
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    exp_q.delete();
    @(negedge clk);
    check("t5_busy",  64'(busy),  64'd0);
    check("t5_grant", 64'(grant), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    load_pkt(0, 8, 1);
    load_pkt(3, 8, 1);
    wait_drain("t5", 20);

`ifdef NOC_ARB_STATS_EN
    // Five packets from input 4 saturate its 2-bit counter at 3.
    do_reset();
    @(negedge clk);
    check("t6_rst_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int p = 0; p < 5; p++) load_pkt(4, 9 + p, 1);
    wait_drain("t6", 60);
    @(negedge clk);
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'h300);
`endif

    repeat (2) @(negedge clk);
    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_out_arbiter.md
# noc_out_arbiter

Wormhole round-robin arbiter for one output port of a mesh NoC router. Up to `NUM_IN` input ports (Local, N, E, S, W) compete for the output. The winner holds the port from head flit through tail flit, and the arbiter then rotates priority. One instance sits in front of each router output link; the routing stage drives its request lines.

## Interface
Parameters:
- `NUM_IN`, default 5: number of requesting input ports.
- `DATA_W`, default 32: flit payload width.
- `CNT_W`, default 16: width of each per-input packet counter. Used only with `NOC_ARB_STATS_EN`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `srst`  in  1: synchronous, active-high reset.
- `in_valid`  in  NUM_IN: flit valid, one bit per input.
- `in_last`  in  NUM_IN: tail-flit marker, one bit per input.
- `in_data`  in  NUM_IN*DATA_W: flit payloads; input i occupies bits [i*DATA_W +: DATA_W].
- `in_ready`  out  NUM_IN: per-input accept.
- `out_valid`  out  1: output flit valid.
- `out_last`  out  1: output tail marker.
- `out_data`  out  DATA_W: output payload.
- `out_ready`  in  1: downstream accept.
- `grant`  out  NUM_IN: one-hot current owner; all zero when idle.
- `busy`  out  1: high while the port is locked to an owner.
- `pkt_cnt`  out  NUM_IN*CNT_W: completed packets per input. Present only with `NOC_ARB_STATS_EN`.

## Operation
- States:
  - IDLE: no owner.
  - LOCKED: owner register `own` is valid.
- Round-robin pointer `ptr` holds the index of the last owner.
  - Search order is `ptr+1`, `ptr+2`, … modulo `NUM_IN`.
  - The first input with `in_valid` set wins.
- IDLE, any `in_valid` set: at the next edge, `own` takes the winner and the state goes to LOCKED.
  - `in_ready` is all zero in IDLE, so no flit transfers in the arbitration cycle.
- LOCKED:
  - `out_valid` = `in_valid[own]`, `out_last` = `in_last[own]`, `out_data` = payload of input `own`.
  - `in_ready[own]` = `out_ready`; every other `in_ready` bit is 0.
- Transfer: occurs when `out_valid && out_ready`. `in_last` is sampled only on a transfer.
- Tail transfer (transfer with `out_last`): `ptr` takes `own`. Re-arbitrate in the same cycle over `in_valid` with bit `own` masked off:
  - a winner exists → stay LOCKED with `own` = winner (back-to-back, no bubble);
  - no winner → go to IDLE.
- A non-tail transfer, or a stall, leaves the state unchanged. A locked owner is never preempted.
- When not LOCKED, `out_valid`, `out_last` and `out_data` are driven to 0.
- `in_valid` is sticky per the NoC link protocol: it is held until accepted. The arbiter does not check this.

## Timing
- Reset values:
  - state IDLE; `ptr` = NUM_IN-1, so input 0 has highest priority first;
  - `grant` = 0, `busy` = 0, `in_ready` = 0, `out_valid` = 0, `out_last` = 0, `out_data` = 0, `pkt_cnt` = 0.
- Grant latency is 1 cycle from `in_valid` seen in IDLE to the first possible transfer.
- Datapath is combinational from owner to output, with zero added latency. `in_ready` depends combinationally on `out_ready`.
- Back-to-back packets from different inputs incur 0 idle cycles.
- The same input sending consecutive packets with no other requester incurs 1 idle cycle (IDLE re-arbitration).
- `srst` mid-packet:
  - abandons the lock and returns to IDLE with reset values on the next edge;
  - recovery of the partial packet is the link-level responsibility.
- `srst` has priority over every other event in the same cycle.
- `grant` and `busy` are registered outputs that change only on clock edges.

## Configuration
- `NOC_ARB_STATS_EN` defined:
  - `pkt_cnt` port and counters exist.
  - Counter i increments by 1 on each tail transfer from input i.
  - Counters saturate at 2^CNT_W-1 and are cleared by `srst`.
- `NOC_ARB_STATS_EN` undefined: port and counters are absent; arbitration behaviour is identical.

## Structure
- Shared package `noc_pkg` holds:
  - port index constants `PORT_LOCAL`=0, `PORT_N`=1, `PORT_E`=2, `PORT_S`=3, `PORT_W`=4;
  - `NUM_PORTS`=5;
  - the arbiter state enum (IDLE, LOCKED).
- Sub-module `noc_rr_pick`: a combinational round-robin priority selector.
  - Inputs: request vector, mask, pointer.
  - Outputs: one-hot winner and found flag.
  - It is instantiated once and shared by the IDLE path and the tail-transfer path.

## Test plan
- Reset, then `in_valid`=5'b00001 with a 3-flit packet and `out_ready`=1 → `grant`=00001 one cycle later; 3 transfers; `out_last` on the 3rd; state returns to IDLE.
- All 5 inputs request single-flit packets continuously → grant order 0,1,2,3,4,0 with no idle cycles between tails.
- Input 2 locked with a 4-flit packet and `out_ready` low for 3 cycles mid-packet; input 1 also requesting → `grant` stays 00100, no flit is lost, input 1 is granted only after input 2's tail.
- Only input 3 sends two consecutive packets → exactly one IDLE cycle between its tail and its next head.
- `srst` asserted on the 2nd flit of a 4-flit packet → next cycle `busy`=0, `grant`=0, `ptr` back to 4; input 0 wins the next arbitration.
- With `NOC_ARB_STATS_EN` and `CNT_W`=2, send 5 packets from input 4 → `pkt_cnt` for input 4 reads 3 (saturated); all other counters read 0.
